// File: rtl/axis_fwd_pkg.sv
// Shared constants, state encoding and lane helpers for the forward-core
// parameter transmitter.
package axis_fwd_pkg;

  localparam int LANE_W              = 16;
  localparam int LANES               = 4;
  localparam int BEAT_W              = LANE_W * LANES;
  localparam int KEEP_W              = BEAT_W / 8;
  localparam int DEFAULT_FRAME_WORDS = 76;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } tx_state_e;

  // Low bit of the slice occupied by a lane inside a beat.
  function automatic int lane_lo(input logic [1:0] lane);
    return int'(lane) * LANE_W;
  endfunction

  // Byte enables covering lanes 0..last_lane.
  function automatic logic [KEEP_W-1:0] lane_keep(input logic [1:0] last_lane);
    logic [KEEP_W-1:0] k;
    k = '0;
    for (int i = 0; i < LANES; i++)
      if (i <= int'(last_lane)) k[i*(LANE_W/8) +: (LANE_W/8)] = '1;
    return k;
  endfunction

endpackage

// File: rtl/axis_param_tx_if.sv
// Word-stream input and packed AXIS output of the parameter transmitter.
// master: the transmitter side. slave: the source/sink side (bench, neighbours).
// m_axis_tkeep exists only when AXIS_PARAM_TX_TKEEP_EN is defined.
interface axis_param_tx_if;

  logic [axis_fwd_pkg::LANE_W-1:0] s_word_tdata;
  logic                            s_word_tvalid;
  logic                            s_word_tready;
  logic [axis_fwd_pkg::BEAT_W-1:0] m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tready;
  logic                            m_axis_tlast;
`ifdef AXIS_PARAM_TX_TKEEP_EN
  logic [axis_fwd_pkg::KEEP_W-1:0] m_axis_tkeep;
`endif

  modport master (
`ifdef AXIS_PARAM_TX_TKEEP_EN
    output m_axis_tkeep,
`endif
    input  s_word_tdata, s_word_tvalid, m_axis_tready,
    output s_word_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
`ifdef AXIS_PARAM_TX_TKEEP_EN
    input  m_axis_tkeep,
`endif
    output s_word_tdata, s_word_tvalid, m_axis_tready,
    input  s_word_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

endinterface

// File: rtl/axis_param_tx_out_reg.sv
// axis_out_reg: one-entry AXIS holding register. A load may land in the same
// cycle the current beat drains, so a new beat follows with no bubble.
// Keep bits are carried only when AXIS_PARAM_TX_TKEEP_EN is defined.
module axis_out_reg
  import axis_fwd_pkg::*;
(
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_load,
  input  logic [BEAT_W-1:0] i_data,
  input  logic              i_last,
`ifdef AXIS_PARAM_TX_TKEEP_EN
  input  logic [KEEP_W-1:0] i_keep,
  output logic [KEEP_W-1:0] o_keep,
`endif
  input  logic              i_tready,
  output logic              o_valid,
  output logic [BEAT_W-1:0] o_data,
  output logic              o_last,
  output logic              o_free
);

  logic              r_valid;
  logic [BEAT_W-1:0] r_data;
  logic              r_last;
`ifdef AXIS_PARAM_TX_TKEEP_EN
  logic [KEEP_W-1:0] r_keep;
`endif

  // Empty now, or the current beat handshakes this cycle.
  assign o_free = !r_valid || i_tready;

  // Load has priority over drain; payload only changes on a load, which the
  // caller only issues when o_free, so the payload stays stable under stall.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
`ifdef AXIS_PARAM_TX_TKEEP_EN
      r_keep  <= '0;
`endif
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
`ifdef AXIS_PARAM_TX_TKEEP_EN
      r_keep  <= i_keep;
`endif
    end else if (i_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
`ifdef AXIS_PARAM_TX_TKEEP_EN
  assign o_keep  = r_keep;
`endif

endmodule

// File: rtl/axis_param_tx.sv
// axis_param_tx: packs 16-bit Q8.8 words four to a 64-bit AXIS beat, first
// word in the low lane, tlast on the beat holding the frame's last word.
// Optional tkeep output: define AXIS_PARAM_TX_TKEEP_EN.
module axis_param_tx
  import axis_fwd_pkg::*;
#(
  parameter int FRAME_WORDS = DEFAULT_FRAME_WORDS
) (
  input  logic            aclk,
  input  logic            aresetn,
  axis_param_tx_if.master bus,
  output logic            frame_done
);

  localparam logic [0:0]  S_FILL   = FILL;
  localparam logic [0:0]  S_HOLD   = HOLD;
  localparam logic [15:0] LAST_CNT = 16'(FRAME_WORDS - 1);

  logic [0:0]        r_state;
  logic [1:0]        r_lane_idx;
  logic [15:0]       r_word_cnt;
  logic [BEAT_W-1:0] r_asm;
  logic              r_asm_last;
  logic              r_frame_done;

  logic              w_srdy;
  logic              w_take;
  logic              w_last_word;
  logic              w_complete;
  logic [BEAT_W-1:0] w_beat;
  logic              w_out_free;
  logic              w_load;
  logic [BEAT_W-1:0] w_ld_data;
  logic              w_ld_last;
  logic              w_out_valid;
  logic [BEAT_W-1:0] w_out_data;
  logic              w_out_last;
`ifdef AXIS_PARAM_TX_TKEEP_EN
  logic [KEEP_W-1:0] r_asm_keep;
  logic [KEEP_W-1:0] w_ld_keep;
  logic [KEEP_W-1:0] w_out_keep;
`endif

  // Gated by aresetn so tready reads 0 for the whole reset window.
  assign w_srdy      = aresetn && (r_state == S_FILL);
  assign w_take      = bus.s_word_tvalid && w_srdy;
  assign w_last_word = (r_word_cnt == LAST_CNT);
  assign w_complete  = w_take && ((r_lane_idx == 2'd3) || w_last_word);

  // Assembly register with the incoming word merged in; lanes above the
  // current one are still zero because the register clears after each beat.
  always_comb begin
    w_beat = r_asm;
    w_beat[lane_lo(r_lane_idx) +: LANE_W] = bus.s_word_tdata;
  end

  // From HOLD the parked beat goes out; from FILL the freshly completed one.
  assign w_load    = w_out_free && ((r_state == S_HOLD) || w_complete);
  assign w_ld_data = (r_state == S_HOLD) ? r_asm      : w_beat;
  assign w_ld_last = (r_state == S_HOLD) ? r_asm_last : w_last_word;
`ifdef AXIS_PARAM_TX_TKEEP_EN
  assign w_ld_keep = (r_state == S_HOLD) ? r_asm_keep : lane_keep(r_lane_idx);
`endif

  // Lane and frame counters advance on every accepted word.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_lane_idx <= 2'd0;
      r_word_cnt <= 16'd0;
    end else if (w_take) begin
      r_lane_idx <= w_complete  ? 2'd0  : r_lane_idx + 2'd1;
      r_word_cnt <= w_last_word ? 16'd0 : r_word_cnt + 16'd1;
    end
  end

  // FSM plus assembly register: a completed beat that cannot leave is parked
  // in the assembly register and input stalls until the output frees.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= S_FILL;
      r_asm      <= '0;
      r_asm_last <= 1'b0;
`ifdef AXIS_PARAM_TX_TKEEP_EN
      r_asm_keep <= '0;
`endif
    end else if (r_state == S_HOLD) begin
      if (w_out_free) begin
        r_state <= S_FILL;
        r_asm   <= '0;
      end
    end else if (w_take) begin
      if (w_complete && !w_out_free) begin
        r_state    <= S_HOLD;
        r_asm      <= w_beat;
        r_asm_last <= w_last_word;
`ifdef AXIS_PARAM_TX_TKEEP_EN
        r_asm_keep <= lane_keep(r_lane_idx);
`endif
      end else if (w_complete) begin
        r_asm <= '0;
      end else begin
        r_asm <= w_beat;
      end
    end
  end

  // One-cycle pulse following the tlast handshake.
  always_ff @(posedge aclk) begin
    if (!aresetn) r_frame_done <= 1'b0;
    else          r_frame_done <= w_out_valid && bus.m_axis_tready && w_out_last;
  end

  axis_out_reg u_out (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_load   (w_load),
    .i_data   (w_ld_data),
    .i_last   (w_ld_last),
`ifdef AXIS_PARAM_TX_TKEEP_EN
    .i_keep   (w_ld_keep),
    .o_keep   (w_out_keep),
`endif
    .i_tready (bus.m_axis_tready),
    .o_valid  (w_out_valid),
    .o_data   (w_out_data),
    .o_last   (w_out_last),
    .o_free   (w_out_free)
  );

  assign bus.s_word_tready = w_srdy;
  assign bus.m_axis_tvalid = w_out_valid;
  assign bus.m_axis_tdata  = w_out_data;
  assign bus.m_axis_tlast  = w_out_last;
`ifdef AXIS_PARAM_TX_TKEEP_EN
  assign bus.m_axis_tkeep  = w_out_keep;
`endif
  assign frame_done        = r_frame_done;

endmodule
